// File: rtl/yuv2rgb_pkg.sv
// Shared constants, types and offset helpers for the YCbCr-to-RGB converter.
package yuv2rgb_pkg;

    // Total pipeline depth from input sample to output register.
    localparam int LAT = 6;

    // Coefficients are fixed-point values scaled by 2^Q_SHIFT.
    localparam int Q_SHIFT = 10;
    localparam int Q_RND   = 512;

    // BT.601 limited-range coefficients.
    localparam int KY_601  = 1192;
    localparam int KRV_601 = 1634;
    localparam int KGU_601 = 401;
    localparam int KGV_601 = 832;
    localparam int KBU_601 = 2066;

    // BT.709 limited-range coefficients.
    localparam int KY_709  = 1192;
    localparam int KRV_709 = 1836;
    localparam int KGU_709 = 218;
    localparam int KGV_709 = 547;
    localparam int KBU_709 = 2163;

    // 4:2:2 chroma phase: even pixels carry Cb, odd pixels carry Cr.
    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    // Timing/enable tag that travels beside the pixel data.
    typedef struct packed {
        logic v;
        logic h;
        logic de;
        logic en;
    } tag_t;

    // Luma black level scaled to the component width.
    function automatic int y_off(input int dw);
        return 16 << (dw - 8);
    endfunction

    // Chroma zero level scaled to the component width.
    function automatic int c_off(input int dw);
        return 128 << (dw - 8);
    endfunction

endpackage

// File: rtl/yuv2rgb_cfg_matrix.sv
// Colour matrix: offset subtract, multiply, sum/round and clamp (4 stages).
// The output register loads the fill colour instead of the clamped result
// whenever blank_i is high in the cycle it loads.
module ycc_matrix
    import yuv2rgb_pkg::*;
#(
    parameter int DW = 8,
    parameter logic [3*DW-1:0] FILL_RGB = {{(2*DW){1'b0}}, DW'(255 << (DW - 8))}
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] y_i,
    input  logic [DW-1:0] cb_i,
    input  logic [DW-1:0] cr_i,
    input  logic          std_i,
    input  logic          blank_i,
    output logic [DW-1:0] r_o,
    output logic [DW-1:0] g_o,
    output logic [DW-1:0] b_o
);

    localparam int IW = DW + 2;   // offset-removed component
    localparam int PW = DW + 15;  // product
    localparam int SW = DW + 17;  // sum with headroom

    localparam logic signed [IW-1:0] Y_OFF = IW'(y_off(DW));
    localparam logic signed [IW-1:0] C_OFF = IW'(c_off(DW));
    localparam logic signed [SW-1:0] RND   = SW'(Q_RND);
    localparam logic signed [SW-1:0] MAXV  = SW'((1 << DW) - 1);

    // S2 signals
    logic signed [IW-1:0] y2_d, cb2_d, cr2_d;
    logic signed [IW-1:0] y2_q, cb2_q, cr2_q;
    logic                 std2_q;

    // S3 signals
    logic signed [PW-1:0] y2_x, cb2_x, cr2_x;
    logic signed [PW-1:0] k_y, k_rv, k_gu, k_gv, k_bu;
    logic signed [PW-1:0] p_y_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;

    // S4 signals
    logic signed [SW-1:0] e_y, e_rv, e_gu, e_gv, e_bu;
    logic signed [SW-1:0] r_sum, g_sum, b_sum;
    logic signed [SW-1:0] r4_q, g4_q, b4_q;

    // S5 signals
    logic [DW-1:0] r5_q, g5_q, b5_q;

    function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v);
        logic [DW-1:0] res;
        if (v[SW-1]) begin
            res = '0;
        end else if (v > MAXV) begin
            res = '1;
        end else begin
            res = v[DW-1:0];
        end
        return res;
    endfunction

    assign y2_d  = $signed({2'b00, y_i})  - Y_OFF;
    assign cb2_d = $signed({2'b00, cb_i}) - C_OFF;
    assign cr2_d = $signed({2'b00, cr_i}) - C_OFF;

    // S2: register offset-removed components and the standard select.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y2_q   <= '0;
            cb2_q  <= '0;
            cr2_q  <= '0;
            std2_q <= 1'b0;
        end else begin
            y2_q   <= y2_d;
            cb2_q  <= cb2_d;
            cr2_q  <= cr2_d;
            std2_q <= std_i;
        end
    end

    assign y2_x  = {{(PW-IW){y2_q[IW-1]}},  y2_q};
    assign cb2_x = {{(PW-IW){cb2_q[IW-1]}}, cb2_q};
    assign cr2_x = {{(PW-IW){cr2_q[IW-1]}}, cr2_q};

    assign k_y  = std2_q ? PW'(KY_709)  : PW'(KY_601);
    assign k_rv = std2_q ? PW'(KRV_709) : PW'(KRV_601);
    assign k_gu = std2_q ? PW'(KGU_709) : PW'(KGU_601);
    assign k_gv = std2_q ? PW'(KGV_709) : PW'(KGV_601);
    assign k_bu = std2_q ? PW'(KBU_709) : PW'(KBU_601);

    // S3: the five coefficient products; none can overflow PW bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_y_q  <= '0;
            p_rv_q <= '0;
            p_gu_q <= '0;
            p_gv_q <= '0;
            p_bu_q <= '0;
        end else begin
            p_y_q  <= y2_x  * k_y;
            p_rv_q <= cr2_x * k_rv;
            p_gu_q <= cb2_x * k_gu;
            p_gv_q <= cr2_x * k_gv;
            p_bu_q <= cb2_x * k_bu;
        end
    end

    assign e_y  = {{(SW-PW){p_y_q[PW-1]}},  p_y_q};
    assign e_rv = {{(SW-PW){p_rv_q[PW-1]}}, p_rv_q};
    assign e_gu = {{(SW-PW){p_gu_q[PW-1]}}, p_gu_q};
    assign e_gv = {{(SW-PW){p_gv_q[PW-1]}}, p_gv_q};
    assign e_bu = {{(SW-PW){p_bu_q[PW-1]}}, p_bu_q};

    assign r_sum = e_y + e_rv + RND;
    assign g_sum = e_y - e_gu - e_gv + RND;
    assign b_sum = e_y + e_bu + RND;

    // S4: round-half-up then drop the fractional bits (arithmetic shift).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r4_q <= '0;
            g4_q <= '0;
            b4_q <= '0;
        end else begin
            r4_q <= r_sum >>> Q_SHIFT;
            g4_q <= g_sum >>> Q_SHIFT;
            b4_q <= b_sum >>> Q_SHIFT;
        end
    end

    // S5: clamp to the component range, or load the fill colour when blanked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r5_q <= FILL_RGB[3*DW-1:2*DW];
            g5_q <= FILL_RGB[2*DW-1:DW];
            b5_q <= FILL_RGB[DW-1:0];
        end else if (blank_i) begin
            r5_q <= FILL_RGB[3*DW-1:2*DW];
            g5_q <= FILL_RGB[2*DW-1:DW];
            b5_q <= FILL_RGB[DW-1:0];
        end else begin
            r5_q <= clamp(r4_q);
            g5_q <= clamp(g4_q);
            b5_q <= clamp(b4_q);
        end
    end

    assign r_o = r5_q;
    assign g_o = g5_q;
    assign b_o = b5_q;

endmodule

// File: rtl/yuv2rgb_cfg.sv
// YCbCr (4:4:4 or 4:2:2) to RGB converter with per-frame format/standard
// latch and fill-colour blanking. Fixed 6-cycle latency, one pixel per clock;
// the stream never stalls, so there is no valid/ready handshake: DE marks
// live pixels and every clock advances the whole pipeline.
module yuv2rgb_cfg
    import yuv2rgb_pkg::*;
#(
    parameter int DW = 8,
    parameter logic [3*DW-1:0] FILL_RGB = {{(2*DW){1'b0}}, DW'(255 << (DW - 8))}
) (
    input  logic          iSclk,
    input  logic          iRst,
    input  logic [3*DW-1:0] iD,
    input  logic          iV,
    input  logic          iH,
    input  logic          iE,
    input  logic          iEn,
    input  logic          iFmt,
    input  logic          iStd,
    output logic [DW-1:0] oDesR,
    output logic [DW-1:0] oDesG,
    output logic [DW-1:0] oDesB,
    output logic          oDesV,
    output logic          oDesH,
    output logic          oDesDE,
    output logic [1:0]    oCfg
);

    localparam logic [DW-1:0] C_MID = DW'(c_off(DW));

    // Active configuration
    logic v_prev_q, fmt_q, std_q;

    // S0 / S1 data and per-pixel configuration
    logic [3*DW-1:0] s0_d_q, s1_d_q;
    logic            s0_fmt_q, s0_std_q, s1_fmt_q, s1_std_q;
    phase_e          s1_ph_q;

    // Timing tags, index k aligned with data stage Sk
    tag_t tag_q [LAT];

    // 4:2:2 pairing state
    phase_e        ph_q, ph_d, ph_cur;
    logic          de_rise;
    logic [DW-1:0] hold_cb_q;

    // Chroma-aligned components feeding the matrix
    logic [DW-1:0] own_c, nxt_c, al_y, al_cb, al_cr;

    // Config latch: load format/standard only on the rising edge of iV.
    always_ff @(posedge iSclk or posedge iRst) begin
        if (iRst) begin
            v_prev_q <= 1'b0;
            fmt_q    <= 1'b0;
            std_q    <= 1'b0;
        end else begin
            v_prev_q <= iV;
            if (iV && !v_prev_q) begin
                fmt_q <= iFmt;
                std_q <= iStd;
            end
        end
    end

    // S0/S1 data registers; each pixel carries the config active when sampled.
    always_ff @(posedge iSclk or posedge iRst) begin
        if (iRst) begin
            s0_d_q   <= '0;
            s0_fmt_q <= 1'b0;
            s0_std_q <= 1'b0;
            s1_d_q   <= '0;
            s1_fmt_q <= 1'b0;
            s1_std_q <= 1'b0;
            s1_ph_q  <= PH_EVEN;
        end else begin
            s0_d_q   <= iD;
            s0_fmt_q <= fmt_q;
            s0_std_q <= std_q;
            s1_d_q   <= s0_d_q;
            s1_fmt_q <= s0_fmt_q;
            s1_std_q <= s0_std_q;
            s1_ph_q  <= ph_cur;
        end
    end

    // Tag shift register: V/H/DE/En run alongside data, never gated by DE.
    always_ff @(posedge iSclk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{v: iV, h: iH, de: iE, en: iEn};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Phase FSM state register.
    always_ff @(posedge iSclk or posedge iRst) begin
        if (iRst) begin
            ph_q <= PH_EVEN;
        end else begin
            ph_q <= ph_d;
        end
    end

    // Phase FSM next state: restart at even on rising DE, toggle per DE pixel.
    always_comb begin
        de_rise = tag_q[0].de && !tag_q[1].de;
        ph_cur  = de_rise ? PH_EVEN : ph_q;
        ph_d    = ph_q;
        if (tag_q[0].de) begin
            ph_d = (ph_cur == PH_EVEN) ? PH_ODD : PH_EVEN;
        end
    end

    // Hold the Cb of each even live pixel for its odd partner.
    always_ff @(posedge iSclk or posedge iRst) begin
        if (iRst) begin
            hold_cb_q <= '0;
        end else if (tag_q[1].de && s1_ph_q == PH_EVEN) begin
            hold_cb_q <= own_c;
        end
    end

    // S1 chroma align: rebuild full Cb/Cr for 4:2:2, pass through for 4:4:4.
    always_comb begin
        own_c = s1_d_q[DW-1:0];
        nxt_c = tag_q[0].de ? s0_d_q[DW-1:0] : C_MID;
        al_y  = s1_d_q[3*DW-1:2*DW];
        al_cb = s1_d_q[2*DW-1:DW];
        al_cr = s1_d_q[DW-1:0];
        if (s1_fmt_q) begin
            al_y = s1_d_q[2*DW-1:DW];
            if (s1_ph_q == PH_EVEN) begin
                al_cb = own_c;
                al_cr = nxt_c;
            end else begin
                al_cb = hold_cb_q;
                al_cr = own_c;
            end
        end
    end

    // S2..S5; blanking decided by the tag of the pixel entering S5.
    ycc_matrix #(
        .DW       (DW),
        .FILL_RGB (FILL_RGB)
    ) u_matrix (
        .clk_i   (iSclk),
        .rst_i   (iRst),
        .y_i     (al_y),
        .cb_i    (al_cb),
        .cr_i    (al_cr),
        .std_i   (s1_std_q),
        .blank_i (!tag_q[LAT-2].en),
        .r_o     (oDesR),
        .g_o     (oDesG),
        .b_o     (oDesB)
    );

    assign oDesV  = tag_q[LAT-1].v;
    assign oDesH  = tag_q[LAT-1].h;
    assign oDesDE = tag_q[LAT-1].de;
    assign oCfg   = {fmt_q, std_q};

endmodule

// File: tb/tb_yuv2rgb_cfg.sv
// Directed bench for yuv2rgb_cfg (DW=8) with hand-computed RGB results.
module tb_yuv2rgb_cfg;

    localparam int DW = 8;
    localparam logic [23:0] FILL = 24'h0000FF;

    logic        iSclk = 1'b0;
    logic        iRst;
    logic [23:0] iD;
    logic        iV, iH, iE, iEn, iFmt, iStd;
    logic [7:0]  oDesR, oDesG, oDesB;
    logic        oDesV, oDesH, oDesDE;
    logic [1:0]  oCfg;

    typedef struct {
        int          due;
        logic [2:0]  tim;
        logic        chk;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    yuv2rgb_cfg #(.DW(DW)) dut (
        .iSclk  (iSclk),
        .iRst   (iRst),
        .iD     (iD),
        .iV     (iV),
        .iH     (iH),
        .iE     (iE),
        .iEn    (iEn),
        .iFmt   (iFmt),
        .iStd   (iStd),
        .oDesR  (oDesR),
        .oDesG  (oDesG),
        .oDesB  (oDesB),
        .oDesV  (oDesV),
        .oDesH  (oDesH),
        .oDesDE (oDesDE),
        .oCfg   (oCfg)
    );

    // clock
    always #5 iSclk = ~iSclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; compare every expectation that falls due now.
    task automatic tick();
        exp_t e;
        @(posedge iSclk);
        #1;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("vhde", {29'd0, oDesV, oDesH, oDesDE}, {29'd0, e.tim});
            if (e.chk) begin
                check("rgb", {8'd0, oDesR, oDesG, oDesB}, {8'd0, e.rgb});
            end
        end
    endtask

    task automatic drive(input logic [23:0] d, input logic v, input logic h, input logic e,
                         input logic en, input logic chk, input logic [23:0] rgb);
        exp_t x;
        iD  = d;
        iV  = v;
        iH  = h;
        iE  = e;
        iEn = en;
        x.due = cyc + 6;
        x.tim = {v, h, e};
        x.chk = chk || !en;
        x.rgb = en ? rgb : FILL;
        exp_q.push_back(x);
        tick();
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) begin
            drive(24'($urandom), 1'b0, h, 1'b0, 1'b1, 1'b0, 24'd0);
        end
    endtask

    task automatic px(input logic [23:0] d, input logic [23:0] rgb);
        drive(d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rgb);
    endtask

    task automatic px422(input logic [7:0] y, input logic [7:0] c, input logic [23:0] rgb);
        drive({8'($urandom_range(0, 255)), y, c}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rgb);
    endtask

    task automatic vsync(input logic fmt, input logic std);
        iFmt = fmt;
        iStd = std;
        drive(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        check("cfg_latch", {30'd0, oCfg}, {30'd0, fmt, std});
        drive(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
    endtask

    initial begin
        iRst = 1'b0; iD = '0; iV = 1'b0; iH = 1'b0; iE = 1'b0;
        iEn = 1'b1; iFmt = 1'b0; iStd = 1'b0;
        #1 iRst = 1'b1;
        #1;
        check("rst_rgb", {8'd0, oDesR, oDesG, oDesB}, {8'd0, FILL});
        check("rst_vhde", {29'd0, oDesV, oDesH, oDesDE}, 32'd0);
        check("rst_cfg", {30'd0, oCfg}, 32'd0);
        repeat (3) @(posedge iSclk);
        #1 iRst = 1'b0;
        idle(2, 1'b0);

        // 444 BT.601 basics and clamping
        vsync(1'b0, 1'b0);
        idle(2, 1'b1);
        px({8'd235, 8'd128, 8'd128}, {8'd255, 8'd255, 8'd255});
        px({8'd16,  8'd128, 8'd128}, {8'd0,   8'd0,   8'd0});
        px({8'd81,  8'd90,  8'd240}, {8'd254, 8'd0,   8'd0});
        px({8'd255, 8'd128, 8'd255}, {8'd255, 8'd175, 8'd255});
        px({8'd0,   8'd128, 8'd128}, {8'd0,   8'd0,   8'd0});
        px({8'd128, 8'd160, 8'd100}, {8'd86,  8'd141, 8'd195});
        idle(3, 1'b1);

        // 422: even-length line, then odd-length line (last Cr = 128)
        vsync(1'b1, 1'b0);
        idle(2, 1'b1);
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0, 8'd0});
        idle(3, 1'b1);
        px422(8'd81, 8'd90,  {8'd254, 8'd0,  8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0,  8'd0});
        px422(8'd81, 8'd90,  {8'd76,  8'd91, 8'd0});
        idle(3, 1'b1);

        // Standard change mid-frame waits for the next iV rising edge
        vsync(1'b0, 1'b0);
        idle(2, 1'b0);
        iStd = 1'b1;
        px({8'd81, 8'd90, 8'd240}, {8'd254, 8'd0, 8'd0});
        check("cfg_hold", {30'd0, oCfg}, 32'd0);
        px({8'd128, 8'd160, 8'd100}, {8'd86, 8'd141, 8'd195});
        iFmt = 1'b0;
        drive(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        check("cfg_709", {30'd0, oCfg}, 32'd1);
        iFmt = 1'b1;
        iStd = 1'b0;
        drive(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        check("cfg_vhigh", {30'd0, oCfg}, 32'd1);
        drive(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        check("cfg_vhigh2", {30'd0, oCfg}, 32'd1);
        idle(2, 1'b0);
        px({8'd81,  8'd90,  8'd240}, {8'd255, 8'd24,  8'd0});
        px({8'd128, 8'd160, 8'd100}, {8'd80,  8'd139, 8'd198});

        // Blanking for 10 live cycles, then live output again
        for (int i = 0; i < 10; i++) begin
            drive({8'd81, 8'd90, 8'd240}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'd0);
        end
        px({8'd81, 8'd90, 8'd240}, {8'd255, 8'd24, 8'd0});
        idle(3, 1'b0);

        // Reset in the middle of a 422 line
        vsync(1'b1, 1'b0);
        idle(2, 1'b1);
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        #3 iRst = 1'b1;
        iE = 1'b0;
        #1;
        check("mid_rst_rgb", {8'd0, oDesR, oDesG, oDesB}, {8'd0, FILL});
        check("mid_rst_vhde", {29'd0, oDesV, oDesH, oDesDE}, 32'd0);
        check("mid_rst_cfg", {30'd0, oCfg}, 32'd0);
        exp_q.delete();
        tick();
        iRst = 1'b0;
        idle(2, 1'b0);
        vsync(1'b1, 1'b0);
        idle(2, 1'b1);
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd90,  {8'd254, 8'd0, 8'd0});
        px422(8'd81, 8'd240, {8'd254, 8'd0, 8'd0});
        idle(8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
